y86_dmem_arbiter: RTL

// - Shares the single-ported SEQ data memory between instruction fetch (read-only) and the memory stage.
// - Decodes the memory-stage icode into a read or write, then runs one access at a time through a fixed-latency port.
// - Returns read data or an error to the requester that owns the access.
// - Sits between the fetch and memory stages and the data memory array.

---
 rtl/y86_pkg.sv | 23 ++
 rtl/y86_dmem_arbiter_if.sv | 40 ++++
 rtl/y86_mem_op_decode.sv | 44 ++++
 rtl/y86_dmem_arbiter.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 definitions: memory-touching icodes, arbiter states and an address range helper.
package y86_pkg;

   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } arb_state_t;

   // An 8-byte access starting at addr must fit entirely inside the array.
   function automatic logic addr_ok(input logic [63:0] addr, input logic [63:0] addr_max);
      return addr <= addr_max;
   endfunction

endpackage

// File: rtl/y86_dmem_arbiter_if.sv
// Bundles the fetch, memory-stage and data-memory port signals of the data memory arbiter.
interface y86_dmem_arbiter_if;

   logic        f_req;
   logic [63:0] f_addr;
   logic        f_gnt;
   logic        f_rvalid;
   logic [63:0] f_rdata;
   logic        f_err;

   logic        m_req;
   logic [3:0]  m_icode;
   logic [63:0] m_valA;
   logic [63:0] m_valE;
   logic [63:0] m_valP;
   logic        m_gnt;
   logic        m_done;
   logic [63:0] m_valM;
   logic        m_err;

   logic        mem_en;
   logic        mem_we;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic [63:0] mem_rdata;

   // The arbiter is the slave; requesters plus the memory array form the master side.
   modport slave (
      input  f_req, f_addr, m_req, m_icode, m_valA, m_valE, m_valP, mem_rdata,
      output f_gnt, f_rvalid, f_rdata, f_err, m_gnt, m_done, m_valM, m_err,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output f_req, f_addr, m_req, m_icode, m_valA, m_valE, m_valP, mem_rdata,
      input  f_gnt, f_rvalid, f_rdata, f_err, m_gnt, m_done, m_valM, m_err,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/y86_mem_op_decode.sv
// Maps a Y86 icode and its operands onto a data memory read or write with address and write data.
module y86_mem_op_decode
   import y86_pkg::*;
(
   input  logic [3:0]  icode,
   input  logic [63:0] valA,
   input  logic [63:0] valE,
   input  logic [63:0] valP,
   output logic        is_rd,
   output logic        is_wr,
   output logic [63:0] addr,
   output logic [63:0] wdata
);

   always_comb begin
      is_rd = 1'b0;
      is_wr = 1'b0;
      addr  = 64'd0;
      wdata = 64'd0;
      case (icode)
         IRMMOVQ, IPUSHQ: begin
            is_wr = 1'b1;
            addr  = valE;
            wdata = valA;
         end
         ICALL: begin
            is_wr = 1'b1;
            addr  = valE;
            wdata = valP;
         end
         IMRMOVQ: begin
            is_rd = 1'b1;
            addr  = valE;
         end
         // ret and popq read from the old stack pointer carried in valA.
         IRET, IPOPQ: begin
            is_rd = 1'b1;
            addr  = valA;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/y86_dmem_arbiter.sv
// Shares the single-ported data memory between fetch and the memory stage, one
// fixed-latency access at a time, with a starvation guard for fetch.
module y86_dmem_arbiter
   import y86_pkg::*;
#(
   parameter int MEM_BYTES  = 1024,
   parameter int RD_LAT     = 2,
   parameter int STARVE_LIM = 2
) (
   input logic               clk,
   input logic               rst_n,
   y86_dmem_arbiter_if.slave bus
);

   localparam int          SW       = $clog2(STARVE_LIM + 1);
   localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);
   localparam logic [3:0]  LAT_LOAD = 4'(RD_LAT - 1);

   arb_state_t    state;
   arb_state_t    state_nxt;
   logic [3:0]    lat_cnt;
   logic [SW-1:0] streak;

   logic          owner_f;
   logic          lat_we;
   logic [63:0]   lat_addr;
   logic [63:0]   lat_wdata;

   logic [63:0]   f_rdata_q;
   logic          f_err_q;
   logic [63:0]   m_valm_q;
   logic          m_err_q;

   logic          dec_rd;
   logic          dec_wr;
   logic [63:0]   dec_addr;
   logic [63:0]   dec_wdata;

   logic          m_nop;
   logic          m_bad;
   logic          f_bad;
   logic          force_f;
   logic          grant_m;
   logic          grant_f;

   y86_mem_op_decode u_decode (
      .icode (bus.m_icode),
      .valA  (bus.m_valA),
      .valE  (bus.m_valE),
      .valP  (bus.m_valP),
      .is_rd (dec_rd),
      .is_wr (dec_wr),
      .addr  (dec_addr),
      .wdata (dec_wdata)
   );

   // Memory stage wins unless fetch has been passed over STARVE_LIM times in a row.
   always_comb begin
      m_nop   = !(dec_rd || dec_wr);
      m_bad   = !m_nop && !addr_ok(dec_addr, ADDR_MAX);
      f_bad   = !addr_ok(bus.f_addr, ADDR_MAX);
      force_f = bus.f_req && (streak >= SW'(STARVE_LIM));
      grant_m = rst_n && (state == IDLE) && bus.m_req && !force_f;
      grant_f = rst_n && (state == IDLE) && bus.f_req && !grant_m;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Accesses that never touch memory (NOP or bad address) skip straight to RESP.
   always_comb begin
      state_nxt     = state;
      bus.f_gnt     = grant_f;
      bus.m_gnt     = grant_m;
      bus.f_rvalid  = (state == RESP) && owner_f;
      bus.m_done    = (state == RESP) && !owner_f;
      bus.mem_en    = (state == ISSUE);
      bus.mem_we    = (state == ISSUE) && lat_we;
      bus.mem_addr  = (state == ISSUE) ? lat_addr : 64'd0;
      bus.mem_wdata = (state == ISSUE) ? lat_wdata : 64'd0;
      case (state)
         IDLE: begin
            if (grant_m) begin
               state_nxt = (m_nop || m_bad) ? RESP : ISSUE;
            end else if (grant_f) begin
               state_nxt = f_bad ? RESP : ISSUE;
            end
         end
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (lat_cnt == 4'd0) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request latch, latency counter and per-requester response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_f   <= 1'b0;
         lat_we    <= 1'b0;
         lat_addr  <= 64'd0;
         lat_wdata <= 64'd0;
         lat_cnt   <= 4'd0;
         f_rdata_q <= 64'd0;
         f_err_q   <= 1'b0;
         m_valm_q  <= 64'd0;
         m_err_q   <= 1'b0;
      end else begin
         if (grant_m) begin
            owner_f   <= 1'b0;
            lat_we    <= dec_wr;
            lat_addr  <= dec_addr;
            lat_wdata <= dec_wdata;
            if (m_nop || m_bad) begin
               m_valm_q <= 64'd0;
               m_err_q  <= m_bad;
            end
         end else if (grant_f) begin
            owner_f   <= 1'b1;
            lat_we    <= 1'b0;
            lat_addr  <= bus.f_addr;
            lat_wdata <= 64'd0;
            if (f_bad) begin
               f_rdata_q <= 64'd0;
               f_err_q   <= 1'b1;
            end
         end
         if (state == ISSUE) begin
            lat_cnt <= LAT_LOAD;
         end else if (state == WAIT) begin
            if (lat_cnt == 4'd0) begin
               if (owner_f) begin
                  f_rdata_q <= bus.mem_rdata;
                  f_err_q   <= 1'b0;
               end else begin
                  m_valm_q <= lat_we ? 64'd0 : bus.mem_rdata;
                  m_err_q  <= 1'b0;
               end
            end else begin
               lat_cnt <= lat_cnt - 4'd1;
            end
         end
      end
   end

   // Streak of memory-stage grants that bypassed a waiting fetch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         streak <= '0;
      end else if (!bus.f_req || grant_f) begin
         streak <= '0;
      end else if (grant_m && (streak < SW'(STARVE_LIM))) begin
         streak <= streak + 1'b1;
      end
   end

   assign bus.f_rdata = f_rdata_q;
   assign bus.f_err   = f_err_q;
   assign bus.m_valM  = m_valm_q;
   assign bus.m_err   = m_err_q;

endmodule
